// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package seg7_pkg;

    // Scan FSM encoding, kept as plain constants so older tooling can read it.
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_ON    = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    // LOAD covers the registered nibble plus the decoder's own register stage.
    localparam int LOAD_CYCLES      = 2;
    localparam int DEF_ON_CYCLES    = 50000;
    localparam int DEF_BLANK_CYCLES = 500;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The phase timer holds (length - 1) of the longest phase.
    function automatic int cnt_width(input int on_c, input int blank_c);
        return $clog2(max_int(max_int(on_c, blank_c), LOAD_CYCLES) + 1);
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Loadable down-counter timing one scan phase; done is high on the last cycle of the phase.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none, free-running once loaded.
module seg7_scan_timer #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign done = (cnt == '0);

    // Count down to zero and hold; a load (re)starts the next phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Scans a hex digit buffer across a shared nibble decoder onto one-hot anodes with blanking gaps.
// Latency: per digit 2 load + ON_CYCLES lit + BLANK_CYCLES dark; an_out/seg_out lag the FSM by 1.
// Backpressure: wr_ready drops while a commit waits for the frame boundary; writes then are ignored.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int ON_CYCLES    = DEF_ON_CYCLES,
    parameter  int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int IDX_W        = $clog2(NUM_DIGITS),
    localparam int CNT_W        = cnt_width(ON_CYCLES, BLANK_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [3:0]            wr_value,
    input  logic                  commit,
    output logic                  wr_ready,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [3:0]            dec_num,
    input  logic [6:0]            dec_seg,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] an_out
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W:0]   NUM_IDX   = (IDX_W + 1)'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LOAD_LD   = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LD     = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LD  = CNT_W'(BLANK_CYCLES - 1);

    logic [1:0]            state;
    logic [IDX_W-1:0]      scan_idx;
    logic                  commit_pending;
    logic [3:0]            shadow [NUM_DIGITS];
    logic [3:0]            active [NUM_DIGITS];

    logic                  tmr_done;
    logic [CNT_W-1:0]      tmr_load_val;
    logic                  frame_end;
    logic                  wr_in_range;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;

    // Held off while a commit is waiting, so the shadow copy cannot change under it.
    assign wr_ready    = !commit_pending;
    assign wr_in_range = ({1'b0, wr_idx} < NUM_IDX);

    // The last dark cycle of the last digit is the only place a commit may land.
    assign frame_end = (state == ST_BLANK) && tmr_done && (scan_idx == LAST_IDX);

    // Each phase's timer is reloaded with the length of the phase that follows it.
    always_comb begin
        tmr_load_val = LOAD_LD;
        case (state)
            ST_LOAD:  tmr_load_val = ON_LD;
            ST_ON:    tmr_load_val = BLANK_LD;
            default:  tmr_load_val = LOAD_LD;
        endcase
    end

    // Reset value matches LOAD's length since the FSM restarts in LOAD.
    seg7_scan_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LOAD_LD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_done),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Phase sequencing LOAD -> ON -> BLANK, stepping to the next digit after BLANK.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_LOAD;
            scan_idx <= '0;
        end else if (tmr_done) begin
            case (state)
                ST_LOAD:  state <= ST_ON;
                ST_ON:    state <= ST_BLANK;
                ST_BLANK: begin
                    state    <= ST_LOAD;
                    scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
                end
                default:  state <= ST_LOAD;
            endcase
        end
    end

    // Shadow writes, commit latching, and the frame-aligned shadow->active publish.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
            commit_pending <= 1'b0;
        end else begin
            if (wr_valid && wr_ready && wr_in_range) begin
                shadow[wr_idx] <= wr_value;
            end
            if (frame_end && commit_pending) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
                commit_pending <= 1'b0;
            end else if (commit && wr_ready) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Present the current digit's nibble during LOAD; it stays put through ON.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dec_num <= 4'd0;
        end else if (state == ST_LOAD) begin
            dec_num <= active[scan_idx];
        end
    end

    // Only the ON phase lights anything; blank_mask is applied live per cycle.
    always_comb begin
        an_next  = '0;
        seg_next = 7'd0;
        if (state == ST_ON) begin
            an_next[scan_idx] = 1'b1;
            if (!blank_mask[scan_idx]) begin
                seg_next = dec_seg;
            end
        end
    end

    // Register the pin drivers so anodes and segments switch cleanly on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            an_out  <= '0;
            seg_out <= 7'd0;
        end else begin
            an_out  <= an_next;
            seg_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: random and directed stimulus against a position-based model.
// Latency: expectations are queued before each edge and compared just after it.
// Backpressure: the model tracks commit-pending and drops writes exactly when wr_ready is low.
module tb_seg7_scan_controller;

    localparam int ND  = 4;
    localparam int ONC = 4;
    localparam int BLC = 2;
    localparam int PER = 2 + ONC + BLC;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [1:0] wr_idx;
    logic [3:0] wr_value;
    logic       commit;
    logic       wr_ready;
    logic [3:0] blank_mask;
    logic [3:0] dec_num;
    logic [6:0] dec_seg;
    logic [6:0] seg_out;
    logic [3:0] an_out;

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .NUM_DIGITS   (ND),
        .ON_CYCLES    (ONC),
        .BLANK_CYCLES (BLC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_idx     (wr_idx),
        .wr_value   (wr_value),
        .commit     (commit),
        .wr_ready   (wr_ready),
        .blank_mask (blank_mask),
        .dec_num    (dec_num),
        .dec_seg    (dec_seg),
        .seg_out    (seg_out),
        .an_out     (an_out)
    );

    // Segment pattern gfedcba for each hex nibble.
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // External shared decoder: one registered stage, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) dec_seg <= 7'd0;
        else      dec_seg <= hex_seg(dec_num);
    end

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       rdy;
        logic [3:0] dec;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    // Model: edges since reset give the scan position directly.
    int         m_n;
    logic [3:0] m_sh  [ND];
    logic [3:0] m_act [ND];
    bit         m_pend;
    logic [3:0] m_disp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the following edge.
    task automatic step(input bit r, input bit wv, input logic [1:0] wi, input logic [3:0] wval,
                        input bit cm, input logic [3:0] msk);
        exp_t e;
        int   p;
        int   d;
        bit   rdy;
        bit   on;
        @(negedge clk);
        rst        = r;
        wr_valid   = wv;
        wr_idx     = wi;
        wr_value   = wval;
        commit     = cm;
        blank_mask = msk;
        if (!r) begin
            m_n    = 0;
            m_pend = 1'b0;
            m_disp = 4'd0;
            for (int i = 0; i < ND; i++) begin
                m_sh[i]  = 4'd0;
                m_act[i] = 4'd0;
            end
            e = '{an: 4'd0, seg: 7'd0, rdy: 1'b1, dec: 4'd0};
        end else begin
            p   = m_n % PER;
            d   = (m_n / PER) % ND;
            rdy = !m_pend;
            if (p == 0) m_disp = m_act[d];
            on     = (p >= 2) && (p < 2 + ONC);
            e.an   = on ? 4'(1 << d) : 4'd0;
            e.seg  = (on && !msk[d]) ? hex_seg(m_disp) : 7'd0;
            if (wv && rdy && int'(wi) < ND) m_sh[wi] = wval;
            if (p == PER - 1 && d == ND - 1 && m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end else if (cm && rdy) begin
                m_pend = 1'b1;
            end
            m_n++;
            e.rdy = !m_pend;
            e.dec = m_disp;
        end
        expq.push_back(e);
    endtask

    task automatic idle(input int n, input logic [3:0] msk);
        repeat (n) step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0, msk);
    endtask

    // Monitor: one queued expectation per edge, checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("an_out",   32'(an_out),   32'(e.an));
                chk("seg_out",  32'(seg_out),  32'(e.seg));
                chk("wr_ready", 32'(wr_ready), 32'(e.rdy));
                chk("dec_num",  32'(dec_num),  32'(e.dec));
                chk("an_onehot", 32'($countones(an_out) <= 1), 32'd1);
            end
        end
    end

    initial begin
        int         guard;
        logic [3:0] msk;
        rst        = 1'b0;
        wr_valid   = 1'b0;
        wr_idx     = 2'd0;
        wr_value   = 4'd0;
        commit     = 1'b0;
        blank_mask = 4'd0;

        // Reset, then free scanning of an all-zero buffer.
        repeat (3) step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0);
        idle(40, 4'd0);

        // Fill 1,2,3,4 and commit; new values appear only after the wrap.
        step(1'b1, 1'b1, 2'd0, 4'd1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 2'd1, 4'd2, 1'b0, 4'd0);
        step(1'b1, 1'b1, 2'd2, 4'd3, 1'b0, 4'd0);
        step(1'b1, 1'b1, 2'd3, 4'd4, 1'b0, 4'd0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b1, 4'd0);
        idle(80, 4'd0);

        // Mid-frame commit, then a held write that must be dropped until the boundary.
        idle(5, 4'd0);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b1, 4'd0);
        repeat (40) step(1'b1, 1'b1, 2'd1, 4'hF, 1'b0, 4'd0);
        idle(10, 4'd0);

        // Write and commit in the same cycle.
        step(1'b1, 1'b1, 2'd2, 4'hA, 1'b1, 4'd0);
        idle(70, 4'd0);

        // Digit 2 masked: anode still pulses, segments dark.
        idle(40, 4'b0100);

        // Reset during digit 2 ON with a commit outstanding.
        step(1'b1, 1'b1, 2'd3, 4'h9, 1'b1, 4'd0);
        guard = 0;
        while (!(m_pend && ((m_n / PER) % ND) == 2 &&
                 (m_n % PER) >= 2 && (m_n % PER) < 2 + ONC) && guard < 200) begin
            idle(1, 4'd0);
            guard++;
        end
        total++;
        if (guard >= 200) begin
            bad++;
            $display("FAIL reach_digit2_on: got guard=%0d expected <200", guard);
        end
        step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0);
        idle(40, 4'd0);

        // Randomized traffic with occasional commits, mask changes and resets.
        msk = 4'd0;
        repeat (2000) begin
            if ($urandom_range(0, 49) == 0) msk = 4'($urandom_range(0, 15));
            step($urandom_range(0, 399) != 0,
                 $urandom_range(0, 2) == 0,
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 19) == 0,
                 msk);
        end

        idle(2, msk);
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
